mem_arbiter: RTL and testbench

- Shares the single-port main RAM between the CPU core (MAR/MDR path, port 0) and a DMA/video fetch engine (port 1).
- Grants at most one access per cycle, registers the RAM command, and returns read data with fixed latency.
- CPU has priority. A starvation counter guarantees DMA progress, and a lock input lets the CPU hold the RAM across multi-step stack operations (push/pop/call/return).

---
 rtl/mem_pkg.sv | 21 ++
 rtl/arb_starve_ctr.sv | 35 +++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the main-RAM arbiter files.
//   - ADDR_W_DEF / DATA_W_DEF : default RAM address and data widths
//   - owner_t                 : who owns a RAM command or a read return
//   - lock_state_t            : CPU lock FSM states
package mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of consecutive cycles that a pending
// DMA request has lost arbitration, with a compare against the limit.
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset
//   req      in  DMA request pending this cycle
//   gnt      in  DMA wins arbitration this cycle
//   at_limit out counter has reached LIMIT (DMA must win next, unless locked)
module arb_starve_ctr #(
  parameter int LIMIT = 4  // 1..15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic at_limit
);

  localparam logic [3:0] LIMIT_V = 4'(LIMIT);

  logic [3:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= 4'd0;
    end else if (!req || gnt) begin
      cnt_reg <= 4'd0;
    end else if (cnt_reg != LIMIT_V) begin
      // Holds at the limit while the CPU lock keeps DMA out.
      cnt_reg <= cnt_reg + 4'd1;
    end
  end

  assign at_limit = (cnt_reg == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port main RAM between the CPU (port 0)
// and the DMA/video fetch engine (port 1).
//   Arbitration is combinational in cycle N; the winner's command appears
//   on ramAdrs/ramWe/ramDout and its *Gnt pulses in N+1. Read data from
//   the RAM (ramDin, valid the cycle after the address) is returned on
//   rdata in N+2 with the owner's *RValid.
//   Priority: CPU lock > DMA at starvation limit > CPU > DMA.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cpuReq/cpuWe/cpuAdrs/cpuDin     CPU request and command
//   cpuLock                         keep RAM for the CPU after this grant
//   cpuGnt, cpuRValid, cpuStall     CPU accept pulse, read valid, stall
//   dmaReq/dmaWe/dmaAdrs/dmaDin     DMA request and command
//   dmaGnt, dmaRValid               DMA accept pulse, read valid
//   rdata                           shared read data, qualified by *RValid
//   ramAdrs/ramWe/ramDout/ramDin    RAM command bus and read data
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4  // 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAdrs,
  input  logic [DATA_W-1:0] cpuDin,
  input  logic              cpuLock,
  output logic              cpuGnt,
  output logic              cpuRValid,
  input  logic              dmaReq,
  input  logic              dmaWe,
  input  logic [ADDR_W-1:0] dmaAdrs,
  input  logic [DATA_W-1:0] dmaDin,
  output logic              dmaGnt,
  output logic              dmaRValid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ramAdrs,
  output logic              ramWe,
  output logic [DATA_W-1:0] ramDout,
  input  logic [DATA_W-1:0] ramDin,
  output logic              cpuStall
);

  owner_t      win;
  logic        dma_win;
  logic        dma_at_limit;
  lock_state_t lock_state_reg, lock_state_next;

  logic              cpu_gnt_reg, dma_gnt_reg;
  logic              ram_we_reg;
  logic [ADDR_W-1:0] ram_adrs_reg;
  logic [DATA_W-1:0] ram_dout_reg;
  owner_t            rd_tag_reg;  // owner of the read currently on the bus
  owner_t            rv_tag_reg;  // owner of the read data returning now

  assign dma_win = (win == OWN_DMA);

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (dmaReq),
    .gnt      (dma_win),
    .at_limit (dma_at_limit)
  );

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) lock_state_reg <= LOCK_UNLOCKED;
    else        lock_state_reg <= lock_state_next;
  end

  // Arbitration and lock next-state. Nothing wins while reset is held.
  always_comb begin
    win             = OWN_NONE;
    lock_state_next = lock_state_reg;
    if (rst_n) begin
      if (lock_state_reg == LOCK_LOCKED) begin
        // DMA is shut out entirely, even at the starvation limit.
        if (cpuReq) win = OWN_CPU;
      end else if (dmaReq && dma_at_limit) begin
        win = OWN_DMA;
      end else if (cpuReq) begin
        win = OWN_CPU;
      end else if (dmaReq) begin
        win = OWN_DMA;
      end

      case (lock_state_reg)
        LOCK_UNLOCKED: begin
          if (win == OWN_CPU && cpuLock) lock_state_next = LOCK_LOCKED;
        end
        LOCK_LOCKED: begin
          if (win == OWN_CPU && !cpuLock)     lock_state_next = LOCK_UNLOCKED;
          else if (!cpuReq && !cpuLock)       lock_state_next = LOCK_UNLOCKED;
        end
        default: lock_state_next = LOCK_UNLOCKED;
      endcase
    end
  end

  // Command register and read-return tagging. Address and write data hold
  // through idle cycles; only ramWe drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_gnt_reg  <= 1'b0;
      dma_gnt_reg  <= 1'b0;
      ram_we_reg   <= 1'b0;
      ram_adrs_reg <= '0;
      ram_dout_reg <= '0;
      rd_tag_reg   <= OWN_NONE;
      rv_tag_reg   <= OWN_NONE;
    end else begin
      cpu_gnt_reg <= (win == OWN_CPU);
      dma_gnt_reg <= (win == OWN_DMA);
      ram_we_reg  <= 1'b0;
      rd_tag_reg  <= OWN_NONE;
      rv_tag_reg  <= rd_tag_reg;
      if (win == OWN_CPU) begin
        ram_adrs_reg <= cpuAdrs;
        ram_dout_reg <= cpuDin;
        ram_we_reg   <= cpuWe;
        rd_tag_reg   <= cpuWe ? OWN_NONE : OWN_CPU;
      end else if (win == OWN_DMA) begin
        ram_adrs_reg <= dmaAdrs;
        ram_dout_reg <= dmaDin;
        ram_we_reg   <= dmaWe;
        rd_tag_reg   <= dmaWe ? OWN_NONE : OWN_DMA;
      end
    end
  end

  assign cpuGnt    = cpu_gnt_reg;
  assign dmaGnt    = dma_gnt_reg;
  assign ramWe     = ram_we_reg;
  assign ramAdrs   = ram_adrs_reg;
  assign ramDout   = ram_dout_reg;
  assign cpuRValid = (rv_tag_reg == OWN_CPU);
  assign dmaRValid = (rv_tag_reg == OWN_DMA);
  // ramDin comes from the RAM's own output register; it is forced to zero
  // whenever no read is returning so rdata is clean after reset.
  assign rdata     = (rv_tag_reg != OWN_NONE) ? ramDin : '0;
  assign cpuStall  = rst_n & cpuReq & (win != OWN_CPU);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus for mem_arbiter, checked
// cycle by cycle against a priority-rule reference model and a RAM model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpuReq, cpuWe, cpuLock;
  logic [15:0] cpuAdrs, cpuDin;
  logic        cpuGnt, cpuRValid, cpuStall;
  logic        dmaReq, dmaWe;
  logic [15:0] dmaAdrs, dmaDin;
  logic        dmaGnt, dmaRValid;
  logic [15:0] rdata, ramAdrs, ramDout, ramDin;
  logic        ramWe;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAdrs(cpuAdrs), .cpuDin(cpuDin),
    .cpuLock(cpuLock), .cpuGnt(cpuGnt), .cpuRValid(cpuRValid),
    .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAdrs(dmaAdrs), .dmaDin(dmaDin),
    .dmaGnt(dmaGnt), .dmaRValid(dmaRValid), .rdata(rdata),
    .ramAdrs(ramAdrs), .ramWe(ramWe), .ramDout(ramDout), .ramDin(ramDin),
    .cpuStall(cpuStall)
  );

  // Initial RAM contents (256 words, aliased on the low address byte).
  function automatic logic [15:0] init_word(input int i);
    if (i == 'h40) return 16'hBEEF;
    return 16'((i * 'h0101) ^ 'hA5C3);
  endfunction

  // Synchronous single-port RAM environment.
  bit          env_wr  [256];
  logic [15:0] env_dat [256];
  always @(posedge clk) begin
    if (ramWe) begin
      env_wr[ramAdrs[7:0]]  <= 1'b1;
      env_dat[ramAdrs[7:0]] <= ramDout;
    end else begin
      ramDin <= env_wr[ramAdrs[7:0]] ? env_dat[ramAdrs[7:0]] : init_word(int'(ramAdrs[7:0]));
    end
  end

  // Reference model state: expected outputs for the current cycle.
  logic [15:0] model_mem [256];
  int          m_lock, m_starve;
  bit          e_cg, e_dg, e_we;
  logic [15:0] e_adrs, e_dout, e_rdata;
  int          e_rv;  // 0 none, 1 cpu, 2 dma

  // Outputs observed in the most recent step.
  logic        obs_cg, obs_dg, obs_we, obs_crv, obs_drv, obs_stall;
  logic [15:0] obs_adrs, obs_rdata;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic cyc(input bit r, input bit cr, input bit cw, input logic [15:0] ca,
                     input logic [15:0] cd, input bit cl, input bit dr, input bit dw,
                     input logic [15:0] da, input logic [15:0] dd);
    int          w;
    int          nrv;
    logic [15:0] nrd;
    rst_n = r; cpuReq = cr; cpuWe = cw; cpuAdrs = ca; cpuDin = cd; cpuLock = cl;
    dmaReq = dr; dmaWe = dw; dmaAdrs = da; dmaDin = dd;
    @(negedge clk);
    obs_cg = cpuGnt; obs_dg = dmaGnt; obs_we = ramWe; obs_adrs = ramAdrs;
    obs_crv = cpuRValid; obs_drv = dmaRValid; obs_rdata = rdata; obs_stall = cpuStall;

    // Winner from the priority rules.
    w = 0;
    if (r) begin
      if (m_lock != 0)                  w = cr ? 1 : 0;
      else if (dr && m_starve == LIMIT) w = 2;
      else if (cr)                      w = 1;
      else if (dr)                      w = 2;
    end

    check("cpuGnt",    obs_cg,   e_cg);
    check("dmaGnt",    obs_dg,   e_dg);
    check("ramWe",     obs_we,   e_we);
    check("ramAdrs",   obs_adrs, e_adrs);
    check("ramDout",   ramDout,  e_dout);
    check("cpuRValid", obs_crv,  e_rv == 1);
    check("dmaRValid", obs_drv,  e_rv == 2);
    check("cpuStall",  obs_stall, r && cr && w != 1);
    if (e_rv != 0) check("rdata", obs_rdata, e_rdata);

    // Advance to next cycle's expectations.
    nrv = (r && !e_we) ? (e_cg ? 1 : (e_dg ? 2 : 0)) : 0;
    nrd = model_mem[e_adrs[7:0]];
    if (e_we) model_mem[e_adrs[7:0]] = e_dout;
    if (!r) begin
      e_cg = 0; e_dg = 0; e_we = 0; e_adrs = 0; e_dout = 0;
      m_lock = 0; m_starve = 0;
    end else begin
      e_cg = (w == 1);
      e_dg = (w == 2);
      if (w == 1)      begin e_adrs = ca; e_dout = cd; e_we = cw; end
      else if (w == 2) begin e_adrs = da; e_dout = dd; e_we = dw; end
      else             e_we = 0;
      if (w == 1)                         m_lock = cl ? 1 : 0;
      else if (m_lock != 0 && !cr && !cl) m_lock = 0;
      if (dr && w != 2) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else              m_starve = 0;
    end
    e_rv = nrv;
    e_rdata = nrd;
    $display("cyc rst_n=%0b cpu(req=%0b we=%0b a=%h lk=%0b) dma(req=%0b we=%0b a=%h) -> win=%0d | gnt c/d=%0b/%0b rv c/d=%0b/%0b rdata=%h",
             r, cr, cw, ca, cl, dr, dw, da, w, obs_cg, obs_dg, obs_crv, obs_drv, obs_rdata);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    m_lock = 0; m_starve = 0;
    e_cg = 0; e_dg = 0; e_we = 0; e_adrs = 0; e_dout = 0; e_rdata = 0; e_rv = 0;
    rst_n = 1'b0; cpuReq = 1'b1; cpuWe = 1'b0; cpuAdrs = 0; cpuDin = 0; cpuLock = 1'b0;
    dmaReq = 1'b1; dmaWe = 1'b0; dmaAdrs = 0; dmaDin = 0;
    @(posedge clk);
    #1;

    // Reset held two cycles with both requests high.
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0);
      check("rst_gnt",   {obs_cg, obs_dg, obs_we, obs_crv, obs_drv, obs_stall}, 0);
      check("rst_adrs",  obs_adrs, 16'h0000);
      check("rst_rdata", obs_rdata, 16'h0000);
    end

    // Both requesting continuously: CPU x4 then DMA, repeating.
    for (int k = 0; k < 15; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 16'(16'h0100 + k), 16'h0, 1'b0,
          1'b1, 1'b0, 16'(16'h0200 + k), 16'h0);
      if (k >= 1) begin
        check("seq_cpu", obs_cg, ((k - 1) % 5) != 4);
        check("seq_dma", obs_dg, ((k - 1) % 5) == 4);
      end
    end
    idle();

    // CPU read of 0x0040 returning 0xBEEF.
    cyc(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle();
    check("rd_gnt",  obs_cg, 1);
    check("rd_adrs", obs_adrs, 16'h0040);
    check("rd_we",   obs_we, 0);
    idle();
    check("rd_rv",    obs_crv, 1);
    check("rd_data",  obs_rdata, 16'hBEEF);
    check("rd_dmarv", obs_drv, 0);

    // Locked write then unlocked read of 0x00FF, DMA requesting throughout.
    cyc(1'b1, 1'b1, 1'b1, 16'h00FF, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h0);
    cyc(1'b1, 1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0300, 16'h0);
    check("lk_wr_gnt", {obs_cg, obs_dg, obs_we}, 3'b101);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0300, 16'h0);
    check("lk_rd_gnt", {obs_cg, obs_dg, obs_we}, 3'b100);
    idle();
    check("lk_dma_gnt", {obs_cg, obs_dg}, 2'b01);
    check("lk_rdata",   obs_rdata, 16'h1234);
    idle();

    // DMA read 0x0010 followed by CPU read 0x0020.
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle();
    check("il_dmarv", {obs_drv, obs_crv}, 2'b10);
    check("il_dmadat", obs_rdata, 16'hB5D3);
    idle();
    check("il_cpurv", {obs_drv, obs_crv}, 2'b01);
    check("il_cpudat", obs_rdata, 16'h85E3);

    // Reset in the cycle after a locked CPU read grant.
    cyc(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0400, 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0031, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0400, 16'h0);
    check("mr_gnt", obs_cg, 1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0400, 16'h0);
    check("mr_norv", {obs_crv, obs_cg, obs_dg}, 3'b000);
    idle();
    check("mr_unlock", obs_dg, 1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          16'($urandom), 16'($urandom), $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) < 3, $urandom_range(0, 1) == 1,
          16'($urandom), 16'($urandom));
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
